phase_freq_est: RTL and testbench

- Sits directly downstream of the cordic block in VECTOR mode and consumes its z_o phase stream.
- Phase is signed two's complement, full scale ±pi.
- Per valid sample, the block produces:
  - the wrapped phase difference (instantaneous frequency, FM discriminator output);
  - a running unwrapped phase;
  - a block-averaged frequency estimate over 2^LOG2_AVG deltas.

---
 rtl/phase_freq_est_pkg.sv | 27 ++
 rtl/phase_freq_est_block_avg.sv | 55 +++++
 rtl/phase_freq_est.sv | 76 +++++++
 tb/tb_phase_freq_est.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_freq_est_pkg.sv
// Shared types and arithmetic helpers for the phase/frequency estimator.
// The helpers work on wide words so that callers can truncate them to their own parameter widths.
package phase_freq_est_pkg;

    localparam int PH_BITS_DEF  = 32;
    localparam int MAX_PH_BITS  = 64;
    localparam int MAX_SUM_BITS = 72;

    typedef logic signed [PH_BITS_DEF-1:0] phase_t;

    // Modular subtract. Truncating the result to the phase width gives the wrapped delta in [-pi, pi).
    function automatic logic [MAX_PH_BITS-1:0] wrap_delta(
        input logic [MAX_PH_BITS-1:0] cur,
        input logic [MAX_PH_BITS-1:0] prev
    );
        return cur - prev;
    endfunction

    // Block average as an arithmetic shift, so it rounds toward -inf.
    function automatic logic signed [MAX_SUM_BITS-1:0] avg_shift(
        input logic signed [MAX_SUM_BITS-1:0] sum,
        input int                             log2_n
    );
        return sum >>> log2_n;
    endfunction

endpackage

// File: rtl/phase_freq_est_block_avg.sv
// Accumulates 2^LOG2_AVG wrapped deltas and emits their floor-average as one frequency word.
// A guard of LOG2_AVG bits on the sum makes overflow impossible.
module phase_block_avg
    import phase_freq_est_pkg::*;
#(
    parameter int PH_BITS  = PH_BITS_DEF,
    parameter int LOG2_AVG = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      dvalid,
    input  logic signed [PH_BITS-1:0] dphase,
    output logic                      ovalid,
    output logic signed [PH_BITS-1:0] freq
);

    localparam int SUM_BITS = PH_BITS + LOG2_AVG;
    localparam logic [LOG2_AVG-1:0] CNT_ONE  = 1;
    localparam logic [LOG2_AVG-1:0] CNT_LAST = '1;

    logic signed [SUM_BITS-1:0] sum;
    logic signed [SUM_BITS-1:0] sum_next;
    logic        [LOG2_AVG-1:0] count;

    assign sum_next = sum + {{LOG2_AVG{dphase[PH_BITS-1]}}, dphase};

    always_ff @(posedge clock) begin
        if (!reset) begin
            sum    <= '0;
            count  <= '0;
            ovalid <= 1'b0;
            freq   <= '0;
        end else if (clear) begin
            // A delta arriving during clear belongs to the abandoned stream and is dropped.
            sum    <= '0;
            count  <= '0;
            ovalid <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            if (dvalid) begin
                if (count == CNT_LAST) begin
                    ovalid <= 1'b1;
                    freq   <= PH_BITS'(avg_shift(MAX_SUM_BITS'(sum_next), LOG2_AVG));
                    sum    <= '0;
                    count  <= '0;
                end else begin
                    sum    <= sum_next;
                    count  <= count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/phase_freq_est.sv
// FM discriminator on the cordic phase stream: wrapped delta, unwrapped phase and block-averaged frequency.
// State table:  EMPTY | no previous phase held, next sample only loads it;  RUN | previous phase valid, deltas produced
module phase_freq_est
    import phase_freq_est_pkg::*;
#(
    parameter int PH_BITS  = PH_BITS_DEF,
    parameter int LOG2_AVG = 4,
    parameter int UW_BITS  = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              ivalid,
    input  logic signed [PH_BITS-1:0]         phase_i,
    output logic                              dvalid,
    output logic signed [PH_BITS-1:0]         dphase_o,
    output logic signed [PH_BITS+UW_BITS-1:0] uphase_o,
    output logic                              ovalid,
    output logic signed [PH_BITS-1:0]         freq_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]                        state;
    logic signed [PH_BITS-1:0]         prev;
    logic signed [PH_BITS-1:0]         delta;
    logic signed [PH_BITS+UW_BITS-1:0] phase_ext;
    logic signed [PH_BITS+UW_BITS-1:0] delta_ext;

    assign delta     = PH_BITS'(wrap_delta(MAX_PH_BITS'(phase_i), MAX_PH_BITS'(prev)));
    assign phase_ext = {{UW_BITS{phase_i[PH_BITS-1]}}, phase_i};
    assign delta_ext = {{UW_BITS{delta[PH_BITS-1]}}, delta};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_EMPTY;
            prev     <= '0;
            dvalid   <= 1'b0;
            dphase_o <= '0;
            uphase_o <= '0;
        end else if (clear) begin
            state    <= ST_EMPTY;
            dvalid   <= 1'b0;
            uphase_o <= '0;
        end else begin
            dvalid <= 1'b0;
            if (ivalid) begin
                prev <= phase_i;
                if (state == ST_EMPTY) begin
                    uphase_o <= phase_ext;
                    state    <= ST_RUN;
                end else begin
                    dvalid   <= 1'b1;
                    dphase_o <= delta;
                    // Turn counter lives in the extra MSBs; it wraps silently.
                    uphase_o <= uphase_o + delta_ext;
                end
            end
        end
    end

    phase_block_avg #(
        .PH_BITS  (PH_BITS),
        .LOG2_AVG (LOG2_AVG)
    ) u_block_avg (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .dvalid (dvalid),
        .dphase (dphase_o),
        .ovalid (ovalid),
        .freq   (freq_o)
    );

endmodule

// File: tb/tb_phase_freq_est.sv
// Self-checking bench for phase_freq_est with PH_BITS=32, LOG2_AVG=2, UW_BITS=16.
// A sample-level reference model predicts every output each cycle.
module tb_phase_freq_est;

    localparam int PH   = 32;
    localparam int L    = 2;
    localparam int UW   = 16;
    localparam int N    = 4;
    localparam int RAMP = 34456666;
    localparam longint UMASK = 64'h0000_FFFF_FFFF_FFFF;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      clear;
    logic                      ivalid;
    logic signed [PH-1:0]      phase_i;
    logic                      dvalid;
    logic signed [PH-1:0]      dphase_o;
    logic signed [PH+UW-1:0]   uphase_o;
    logic                      ovalid;
    logic signed [PH-1:0]      freq_o;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit     m_have;
    int     m_prev;
    longint m_uph;
    bit     m_pend;
    int     m_pend_d;
    int     m_blk[$];
    bit     e_dv;
    bit     e_ov;
    int     e_dph;
    int     e_freq;

    logic [113:0] obs;
    logic [113:0] expv;

    phase_freq_est #(
        .PH_BITS  (PH),
        .LOG2_AVG (L),
        .UW_BITS  (UW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .ivalid   (ivalid),
        .phase_i  (phase_i),
        .dvalid   (dvalid),
        .dphase_o (dphase_o),
        .uphase_o (uphase_o),
        .ovalid   (ovalid),
        .freq_o   (freq_o)
    );

    always #5 clock = ~clock;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Apply one cycle of inputs, advance the model, and return at the following negedge.
    task automatic drive_cycle(input bit rst_n, input bit clr, input bit iv, input int ph);
        longint s;
        reset   = rst_n;
        clear   = clr;
        ivalid  = iv;
        phase_i = ph;
        if (!rst_n) begin
            m_have = 0; m_prev = 0; m_uph = 0; m_pend = 0; m_blk.delete();
            e_dv = 0; e_ov = 0; e_dph = 0; e_freq = 0;
        end else if (clr) begin
            m_have = 0; m_uph = 0; m_pend = 0; m_blk.delete();
            e_dv = 0; e_ov = 0;
        end else begin
            e_dv = 0;
            e_ov = 0;
            if (m_pend) begin
                m_blk.push_back(m_pend_d);
                if (m_blk.size() == N) begin
                    s = 0;
                    foreach (m_blk[i]) s += longint'(m_blk[i]);
                    e_freq = int'(floor_div(s, N));
                    e_ov = 1;
                    m_blk.delete();
                end
            end
            m_pend = 0;
            if (iv) begin
                if (!m_have) begin
                    m_have = 1;
                    m_uph  = longint'(ph) & UMASK;
                end else begin
                    e_dph    = ph - m_prev;
                    e_dv     = 1;
                    m_uph    = (m_uph + longint'(e_dph)) & UMASK;
                    m_pend   = 1;
                    m_pend_d = e_dph;
                end
                m_prev = ph;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(0, c[0], 1, int'($urandom));
            n_vec++;
            obs = {dvalid, dphase_o, uphase_o, ovalid, freq_o};
            if (obs !== 114'd0) begin
                n_err++;
                $display("FAIL reset cyc %0d got %h exp 0", c, obs);
            end
        end
    endtask

    task automatic test_ramp();
        int n_dv = 0;
        int n_ov = 0;
        int n_ok = 0;
        drive_cycle(1, 1, 0, 0);
        for (int k = 0; k <= 9; k++) begin
            if (k < 9) drive_cycle(1, 0, 1, k * RAMP);
            else       drive_cycle(1, 0, 0, 0);
            n_vec++;
            obs  = {dvalid, dphase_o, uphase_o, ovalid, freq_o};
            expv = {e_dv, e_dph, m_uph[47:0], e_ov, e_freq};
            if (obs !== expv) begin
                n_err++;
                $display("FAIL ramp cyc %0d got %h exp %h", k, obs, expv);
            end
            if (dvalid) n_dv++;
            if (ovalid) begin
                n_ov++;
                if (freq_o == RAMP) n_ok++;
            end
        end
        n_vec++;
        if (n_dv != 8 || n_ov != 2 || n_ok != 2 || uphase_o !== 48'd275653328) begin
            n_err++;
            $display("FAIL ramp_summary got dv=%0d ov=%0d ok=%0d uph=%0d exp dv=8 ov=2 ok=2 uph=275653328",
                     n_dv, n_ov, n_ok, uphase_o);
        end
    endtask

    task automatic test_wrap();
        drive_cycle(1, 1, 0, 0);
        drive_cycle(1, 0, 1, 32'h7FFF0000);
        drive_cycle(1, 0, 1, 32'h80010000);
        n_vec++;
        obs  = {dvalid, dphase_o, uphase_o, ovalid, freq_o};
        expv = {e_dv, e_dph, m_uph[47:0], e_ov, e_freq};
        if (obs !== expv) begin
            n_err++;
            $display("FAIL wrap_model got %h exp %h", obs, expv);
        end
        n_vec++;
        if (dvalid !== 1'b1 || dphase_o !== 32'h00020000 || uphase_o !== 48'h0000_8001_0000) begin
            n_err++;
            $display("FAIL wrap got dv=%0b d=%h u=%h exp dv=1 d=00020000 u=000080010000",
                     dvalid, dphase_o, uphase_o);
        end
    endtask

    task automatic test_rounding();
        int offs[9] = '{0, 1, 3, 6, 5, 4, 2, -1, 0};
        int base;
        int got[$];
        base = int'($urandom);
        drive_cycle(1, 1, 0, 0);
        for (int k = 0; k <= 9; k++) begin
            if (k < 9) drive_cycle(1, 0, 1, base + offs[k]);
            else       drive_cycle(1, 0, 0, 0);
            n_vec++;
            obs  = {dvalid, dphase_o, uphase_o, ovalid, freq_o};
            expv = {e_dv, e_dph, m_uph[47:0], e_ov, e_freq};
            if (obs !== expv) begin
                n_err++;
                $display("FAIL rounding cyc %0d got %h exp %h", k, obs, expv);
            end
            if (ovalid) got.push_back(freq_o);
        end
        n_vec++;
        if (got.size() != 2 || got[0] != 1 || got[1] != -2) begin
            n_err++;
            $display("FAIL rounding_freq got n=%0d f0=%0d f1=%0d exp n=2 f0=1 f1=-2",
                     got.size(), (got.size() > 0) ? got[0] : 0, (got.size() > 1) ? got[1] : 0);
        end
    endtask

    task automatic test_gaps();
        int n_dv = 0;
        int n_ov = 0;
        int n_ok = 0;
        drive_cycle(1, 1, 0, 0);
        for (int c = 0; c < 27; c++) begin
            if (c % 3 == 0) drive_cycle(1, 0, 1, (c / 3) * RAMP);
            else            drive_cycle(1, 0, 0, int'($urandom));
            n_vec++;
            obs  = {dvalid, dphase_o, uphase_o, ovalid, freq_o};
            expv = {e_dv, e_dph, m_uph[47:0], e_ov, e_freq};
            if (obs !== expv) begin
                n_err++;
                $display("FAIL gaps cyc %0d got %h exp %h", c, obs, expv);
            end
            if (dvalid) n_dv++;
            if (ovalid) begin
                n_ov++;
                if (freq_o == RAMP) n_ok++;
            end
        end
        n_vec++;
        if (n_dv != 8 || n_ov != 2 || n_ok != 2 || uphase_o !== 48'd275653328) begin
            n_err++;
            $display("FAIL gaps_summary got dv=%0d ov=%0d ok=%0d uph=%0d exp dv=8 ov=2 ok=2 uph=275653328",
                     n_dv, n_ov, n_ok, uphase_o);
        end
    endtask

    // flush = 0 uses clear, flush = 1 uses a one-cycle reset, each after two deltas of a block
    task automatic test_flush(input bit use_reset);
        int n_ov = 0;
        int last_ov = -1;
        drive_cycle(1, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive_cycle(1, 0, 1, int'($urandom));
        if (use_reset) drive_cycle(0, 0, 1, int'($urandom));
        else           drive_cycle(1, 1, 1, int'($urandom));
        n_vec++;
        obs = {dvalid, dphase_o, uphase_o, ovalid, freq_o};
        expv = {e_dv, e_dph, m_uph[47:0], e_ov, e_freq};
        if (obs !== expv || dvalid !== 1'b0 || ovalid !== 1'b0 || uphase_o !== 48'd0 ||
            (use_reset && obs !== 114'd0)) begin
            n_err++;
            $display("FAIL flush%0d_after got %h exp %h", use_reset, obs, expv);
        end
        for (int c = 0; c < 7; c++) begin
            if (c < 5) drive_cycle(1, 0, 1, int'($urandom));
            else       drive_cycle(1, 0, 0, 0);
            n_vec++;
            obs  = {dvalid, dphase_o, uphase_o, ovalid, freq_o};
            expv = {e_dv, e_dph, m_uph[47:0], e_ov, e_freq};
            if (obs !== expv || (c == 0 && dvalid !== 1'b0)) begin
                n_err++;
                $display("FAIL flush%0d cyc %0d got %h exp %h", use_reset, c, obs, expv);
            end
            if (ovalid) begin
                n_ov++;
                last_ov = c;
            end
        end
        n_vec++;
        if (n_ov != 1 || last_ov != 5) begin
            n_err++;
            $display("FAIL flush%0d_block got n_ov=%0d at=%0d exp n_ov=1 at=5", use_reset, n_ov, last_ov);
        end
    endtask

    task automatic test_back_to_back();
        int n_ov = 0;
        drive_cycle(1, 1, 0, 0);
        for (int c = 0; c < 42; c++) begin
            if (c < 41) drive_cycle(1, 0, 1, int'($urandom));
            else        drive_cycle(1, 0, 0, 0);
            n_vec++;
            obs  = {dvalid, dphase_o, uphase_o, ovalid, freq_o};
            expv = {e_dv, e_dph, m_uph[47:0], e_ov, e_freq};
            if (obs !== expv) begin
                n_err++;
                $display("FAIL b2b cyc %0d got %h exp %h", c, obs, expv);
            end
            if (ovalid) n_ov++;
        end
        n_vec++;
        if (n_ov != 10) begin
            n_err++;
            $display("FAIL b2b_count got %0d exp 10", n_ov);
        end
    endtask

    task automatic test_random();
        bit rst_n;
        bit clr;
        bit iv;
        int ph;
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(99) != 0);
            clr   = ($urandom_range(49) == 0);
            iv    = ($urandom_range(3) != 0);
            ph    = ($urandom_range(3) == 0) ? int'($urandom_range(2047)) - 1024 : int'($urandom);
            drive_cycle(rst_n, clr, iv, ph);
            n_vec++;
            obs  = {dvalid, dphase_o, uphase_o, ovalid, freq_o};
            expv = {e_dv, e_dph, m_uph[47:0], e_ov, e_freq};
            if (obs !== expv) begin
                n_err++;
                $display("FAIL random cyc %0d got %h exp %h", c, obs, expv);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        clear   = 1'b0;
        ivalid  = 1'b0;
        phase_i = '0;
        test_reset();
        test_ramp();
        test_wrap();
        test_rounding();
        test_gaps();
        test_flush(1'b0);
        test_flush(1'b1);
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
